// File: rtl/mac_skew_feeder.sv
// Skewing feeder for the systolic MAC array: each lane k is delayed k cycles, and the job is followed by a zero flush.
// Optional build macro SKEW_FEEDER_BUBBLE_CNT_EN adds o_bubbles, a count of STREAM cycles with s_valid low.
module mac_skew_feeder #(
  parameter int ARR_SIZE      = 4,
  parameter int HORIZONTAL_BW = 16,
  parameter int LEN_W         = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [LEN_W-1:0]                  i_len,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_data,
  output logic [HORIZONTAL_BW*ARR_SIZE-1:0] o_data,
  output logic                              o_active,
  output logic                              o_done
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [LEN_W-1:0]                  o_bubbles
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int FCW = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'((ARR_SIZE > 1) ? ARR_SIZE - 2 : 0);

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [FCW-1:0]   flush_q, flush_d;
  logic             done_q, done_d;
  logic             hs;

  assign s_ready  = (state_q == STREAM);
  assign o_active = (state_q == STREAM) || (state_q == FLUSH);
  assign o_done   = done_q;
  assign hs       = s_valid && s_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through the case leaves a latch.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            len_d   = i_len;
            cnt_d   = '0;
            state_d = STREAM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            flush_d = '0;
            state_d = (ARR_SIZE > 1) ? FLUSH : DONE;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FLUSH_LAST) state_d = DONE;
      end
      DONE: begin
        // The pulse is registered, so it appears on the cycle after the last skewed lane drains.
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
    logic [HORIZONTAL_BW-1:0] chain_q [0:k];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // NOTE: the delay chain is reset, unlike a RAM, because an abort must leave zeros on o_data.
        for (int j = 0; j <= k; j++) chain_q[j] <= '0;
      end else begin
        chain_q[0] <= hs ? s_data[k*HORIZONTAL_BW +: HORIZONTAL_BW] : '0;
        for (int j = 1; j <= k; j++) chain_q[j] <= chain_q[j-1];
      end
    end

    assign o_data[k*HORIZONTAL_BW +: HORIZONTAL_BW] = chain_q[k];
  end

`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  logic [LEN_W-1:0] bub_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bub_q <= '0;
    end else if (state_q == IDLE && i_start) begin
      bub_q <= '0;
    end else if (state_q == STREAM && !s_valid && bub_q != '1) begin
      bub_q <= bub_q + 1'b1;
    end
  end

  assign o_bubbles = bub_q;
`endif

endmodule

// File: tb/tb_mac_skew_feeder.sv
// Directed bench for mac_skew_feeder. A transaction-level scoreboard schedules each accepted lane at its skewed cycle
// and queues the expected o_done cycles.
module tb_mac_skew_feeder;
  localparam int ARR = 4;
  localparam int HBW = 16;
  localparam int LW  = 8;
  localparam int W   = ARR * HBW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic [W-1:0]  o_data;
  logic          o_active;
  logic          o_done;
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
  logic [LW-1:0] o_bubbles;
`endif

  mac_skew_feeder #(.ARR_SIZE(ARR), .HORIZONTAL_BW(HBW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .o_data(o_data), .o_active(o_active), .o_done(o_done)
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    , .o_bubbles(o_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_map [int];
  int           done_q [$];
  logic         m_idle = 1'b1;
  logic         m_rdy  = 1'b0;
  int           m_left = 0;
  int           m_bub  = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] vec(input int n);
    logic [W-1:0] v;
    for (int k = 0; k < ARR; k++) v[k*HBW +: HBW] = HBW'(k + 1 + 10 * n);
    return v;
  endfunction

  // One cycle: drive inputs after the falling edge, update the model, clock, then compare on the next falling edge.
  task automatic step(input logic start, input logic [LW-1:0] len, input logic v, input logic [W-1:0] d);
    logic [W-1:0] e;
    logic         exp_done;
    logic         exp_active;
    i_start = start;
    i_len   = len;
    s_valid = v;
    s_data  = d;
    #1;
    check("s_ready", W'(s_ready), W'(m_rdy));
    if (m_rdy && !v && m_bub < (1 << LW) - 1) m_bub++;
    if (v && m_rdy) begin
      for (int k = 0; k < ARR; k++) begin
        e = exp_map.exists(cyc + 1 + k) ? exp_map[cyc + 1 + k] : '0;
        e[k*HBW +: HBW] = d[k*HBW +: HBW];
        exp_map[cyc + 1 + k] = e;
      end
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b0;
        done_q.push_back(cyc + 1 + ARR);
      end
    end
    if (start && m_idle) begin
      m_bub = 0;
      if (len != '0) begin
        m_idle = 1'b0;
        m_rdy  = 1'b1;
        m_left = int'(len);
      end else begin
        done_q.push_back(cyc + 1);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    e = exp_map.exists(cyc) ? exp_map[cyc] : '0;
    if (exp_map.exists(cyc)) exp_map.delete(cyc);
    check("o_data", o_data, e);
    exp_done = (done_q.size() > 0 && done_q[0] == cyc);
    if (exp_done) begin
      void'(done_q.pop_front());
      m_idle = 1'b1;
    end
    check("o_done", W'(o_done), W'(exp_done));
    exp_active = !m_idle && !(done_q.size() > 0 && done_q[0] == cyc + 1);
    check("o_active", W'(o_active), W'(exp_active));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_bubbles();
`ifdef SKEW_FEEDER_BUBBLE_CNT_EN
    check("o_bubbles", W'(o_bubbles), W'(m_bub));
`endif
  endtask

  initial begin
    #2;
    check("rst_o_data", o_data, '0);
    check("rst_s_ready", W'(s_ready), '0);
    check("rst_o_active", W'(o_active), '0);
    check("rst_o_done", W'(o_done), '0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Three back-to-back vectors: lane k shows vector n on cycle n+1+k after start, done follows the drain.
    step(1'b1, 8'd3, 1'b0, '0);
    for (int n = 0; n < 3; n++) step(1'b0, '0, 1'b1, vec(n));
    idle(ARR + 2);
    check_bubbles();

    // A bubble between two vectors must appear as an aligned zero slot on every lane.
    step(1'b1, 8'd2, 1'b0, '0);
    step(1'b0, '0, 1'b1, vec(3));
    step(1'b0, '0, 1'b0, vec(9));
    step(1'b0, '0, 1'b1, vec(4));
    idle(ARR + 2);
    check_bubbles();

    // Zero-length job: done on the next cycle without ever raising s_ready.
    step(1'b1, 8'd0, 1'b1, vec(7));
    idle(3);

    // A restart during STREAM with another length is ignored.
    step(1'b1, 8'd2, 1'b0, '0);
    step(1'b0, '0, 1'b1, vec(5));
    step(1'b1, 8'd9, 1'b0, vec(8));
    step(1'b0, '0, 1'b1, vec(6));
    idle(ARR + 3);
    check_bubbles();

    // Full-length job with random data and random stalls exercises the count boundary.
    step(1'b1, 8'd255, 1'b0, '0);
    while (m_rdy) begin
      logic [W-1:0] d;
      d = {$urandom, $urandom};
      step(1'b0, '0, ($urandom_range(0, 3) != 0), d);
    end
    idle(ARR + 2);
    check_bubbles();

    // Reset in the middle of FLUSH aborts at once and never pulses o_done.
    step(1'b1, 8'd3, 1'b0, '0);
    for (int n = 0; n < 3; n++) step(1'b0, '0, 1'b1, vec(20 + n));
    step(1'b0, '0, 1'b0, '0);
    #2;
    rst = 1'b0;
    #1;
    check("abort_o_data", o_data, '0);
    check("abort_o_active", W'(o_active), '0);
    check("abort_s_ready", W'(s_ready), '0);
    exp_map.delete();
    done_q.delete();
    m_idle = 1'b1;
    m_rdy  = 1'b0;
    m_left = 0;
    m_bub  = 0;
    @(negedge clk);
    check("abort_o_done", W'(o_done), '0);
    rst = 1'b1;
    idle(ARR + 3);
    check_bubbles();

    // The feeder must be usable again after the abort.
    step(1'b1, 8'd1, 1'b0, '0);
    step(1'b0, '0, 1'b1, vec(30));
    idle(ARR + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
